// File: rtl/store_drain_queue_pkg.sv
// rtl/store_drain_queue_pkg.sv - shared entry and drain-state types for the committed store drain queue
package store_drain_queue_pkg;

    localparam int SDQ_DATA_W = 32;
    localparam int SDQ_STRB_W = 4;

    typedef struct packed {
        logic                  valid;
        logic [SDQ_DATA_W-1:0] addr;
        logic [SDQ_STRB_W-1:0] wstrb;
        logic [SDQ_DATA_W-1:0] wdata;
    } store_entry_t;

    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_REQ  = 2'd1,
        DRAIN_WAIT = 2'd2
    } drain_state_e;

endpackage

// File: rtl/store_byte_merge.sv
// rtl/store_byte_merge.sv - byte-lane merge of a new store over an older one (combinational)
module store_byte_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] old_data,
    input  logic [3:0]            old_strb,
    input  logic [DATA_WIDTH-1:0] new_data,
    input  logic [3:0]            new_strb,
    output logic [DATA_WIDTH-1:0] merged_data,
    output logic [3:0]            merged_strb
);

    localparam int LANE_W = DATA_WIDTH / 4;

    always_comb begin
        merged_strb = old_strb | new_strb;
        merged_data = old_data;
        for (int i = 0; i < 4; i++) begin
            if (new_strb[i]) begin
                merged_data[i*LANE_W +: LANE_W] = new_data[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/store_drain_queue.sv
// rtl/store_drain_queue.sv - in-order committed store FIFO draining to the dcache req/addr_ok/data_ok port
// Optional STORE_MERGE_EN: same-word pushes merge into the youngest entry.
module store_drain_queue
    import store_drain_queue_pkg::*;
#(
    parameter  int DATA_WIDTH = SDQ_DATA_W,
    parameter  int DEPTH      = 8,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk_g,
    input  logic                  reset,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_addr,
    input  logic [3:0]            push_wstrb,
    input  logic [DATA_WIDTH-1:0] push_wdata,
    output logic                  push_ready,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [3:0]            data_wstrb,
    output logic [DATA_WIDTH-1:0] data_addr,
    output logic [DATA_WIDTH-1:0] data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [DATA_WIDTH-1:0] ld_addr,
    output logic                  ld_conflict,
    output logic                  drain_empty,
    output logic [PTR_W:0]        drain_count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    store_entry_t          entries [DEPTH];
    store_entry_t          wr_entry;
    store_entry_t          load_entry;
    drain_state_e          state;
    logic [PTR_W-1:0]      head, tail, wr_idx, load_idx;
    logic [PTR_W:0]        count, count_next;
    logic                  merge_hit, push_acc, alloc, retire;
    logic [DATA_WIDTH-1:0] base_data, merged_data;
    logic [3:0]            base_strb, merged_strb;
    logic                  unused_ok;

    assign unused_ok = &{1'b0, push_addr[1:0], ld_addr[1:0]};

`ifdef STORE_MERGE_EN
    logic [PTR_W-1:0] youngest;
    assign youngest  = tail - 1'b1;
    // The head is frozen on the cache port once a request is in flight.
    assign merge_hit = push_valid && (count != '0) && entries[youngest].valid
                    && (entries[youngest].addr[DATA_WIDTH-1:2] == push_addr[DATA_WIDTH-1:2])
                    && !((youngest == head) && (state != DRAIN_IDLE));
    assign base_data = merge_hit ? entries[youngest].wdata : '0;
    assign base_strb = merge_hit ? entries[youngest].wstrb : '0;
    assign wr_idx    = merge_hit ? youngest : tail;
`else
    assign merge_hit = 1'b0;
    assign base_data = '0;
    assign base_strb = '0;
    assign wr_idx    = tail;
`endif

    store_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
        .old_data    (base_data),
        .old_strb    (base_strb),
        .new_data    (push_wdata),
        .new_strb    (push_wstrb),
        .merged_data (merged_data),
        .merged_strb (merged_strb)
    );

    assign push_ready = (count != FULL_COUNT) || merge_hit;
    assign push_acc   = push_valid && push_ready;
    assign alloc      = push_acc && !merge_hit;
    assign retire     = ((state == DRAIN_REQ) && data_addr_ok && data_data_ok)
                     || ((state == DRAIN_WAIT) && data_data_ok);

    always_comb begin
        wr_entry       = '0;
        wr_entry.valid = 1'b1;
        wr_entry.addr  = {push_addr[DATA_WIDTH-1:2], 2'b00};
        wr_entry.wstrb = merged_strb;
        wr_entry.wdata = merged_data;
    end

    always_comb begin
        count_next = count;
        if (alloc && !retire) begin
            count_next = count + 1'b1;
        end else if (!alloc && retire) begin
            count_next = count - 1'b1;
        end
    end

    // Entry to present next; bypasses a push landing in that slot on the same edge.
    assign load_idx   = (state == DRAIN_IDLE) ? head : head + 1'b1;
    assign load_entry = (push_acc && (wr_idx == load_idx)) ? wr_entry : entries[load_idx];

    always_ff @(posedge clk_g or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (retire) begin
                entries[head].valid <= 1'b0;
            end
            if (push_acc) begin
                entries[wr_idx] <= wr_entry;
            end
        end
    end

    always_ff @(posedge clk_g or negedge reset) begin
        if (!reset) begin
            state      <= DRAIN_IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            data_req   <= 1'b0;
            data_addr  <= '0;
            data_wdata <= '0;
            data_wstrb <= '0;
        end else begin
            if (alloc) begin
                tail <= tail + 1'b1;
            end
            if (retire) begin
                head <= head + 1'b1;
            end
            count <= count_next;
            case (state)
                DRAIN_IDLE: begin
                    if (count != '0) begin
                        state      <= DRAIN_REQ;
                        data_req   <= 1'b1;
                        data_addr  <= load_entry.addr;
                        data_wdata <= load_entry.wdata;
                        data_wstrb <= load_entry.wstrb;
                    end
                end
                DRAIN_REQ, DRAIN_WAIT: begin
                    if (retire) begin
                        if (count_next != '0) begin
                            state      <= DRAIN_REQ;
                            data_req   <= 1'b1;
                            data_addr  <= load_entry.addr;
                            data_wdata <= load_entry.wdata;
                            data_wstrb <= load_entry.wstrb;
                        end else begin
                            state    <= DRAIN_IDLE;
                            data_req <= 1'b0;
                        end
                    end else if ((state == DRAIN_REQ) && data_addr_ok) begin
                        state    <= DRAIN_WAIT;
                        data_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= DRAIN_IDLE;
                    data_req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid && (entries[i].addr[DATA_WIDTH-1:2] == ld_addr[DATA_WIDTH-1:2])) begin
                ld_conflict = 1'b1;
            end
        end
    end

    assign data_wr     = 1'b1;
    assign drain_empty = (count == '0) && (state == DRAIN_IDLE);
    assign drain_count = count;

    a_no_push_when_full: assert property (@(posedge clk_g) disable iff (!reset) push_valid |-> push_ready);

endmodule

// File: tb/tb_store_drain_queue.sv
// tb/tb_store_drain_queue.sv - directed self-checking bench for store_drain_queue
module tb_store_drain_queue;

    logic        clk_g = 1'b0;
    logic        reset = 1'b0;
    logic        push_valid = 1'b0;
    logic [31:0] push_addr = '0;
    logic [3:0]  push_wstrb = '0;
    logic [31:0] push_wdata = '0;
    logic        push_ready;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        ld_conflict, drain_empty;
    logic [3:0]  drain_count;

    int checks = 0;
    int failures = 0;

    store_drain_queue dut (
        .clk_g(clk_g), .reset(reset),
        .push_valid(push_valid), .push_addr(push_addr), .push_wstrb(push_wstrb), .push_wdata(push_wdata),
        .push_ready(push_ready),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict), .drain_empty(drain_empty), .drain_count(drain_count)
    );

    always #5 clk_g = ~clk_g;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk_g);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        push_valid = 1'b1; push_addr = a; push_wstrb = s; push_wdata = d;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic wait_req;
        for (int k = 0; k < 50 && !data_req; k++) tick();
    endtask

    task automatic retire_one;
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick(); tick();
        checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", data_req); end
        checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", push_ready); end
        checks++; if (drain_empty !== 1'b1 || drain_count !== 4'd0) begin failures++; $display("FAIL reset_empty got=%b/%0d exp=1/0", drain_empty, drain_count); end
        checks++; if (data_addr !== 32'h0 || data_wdata !== 32'h0 || data_wstrb !== 4'h0) begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", data_addr, data_wdata, data_wstrb); end
        checks++; if (ld_conflict !== 1'b0 || data_wr !== 1'b1) begin failures++; $display("FAIL reset_misc got=%b/%b exp=0/1", ld_conflict, data_wr); end
        @(negedge clk_g); reset = 1'b1;
        tick();
    endtask

    task automatic test_single;
        push(32'h8000_0010, 4'hf, 32'hDEAD_BEEF);
        checks++; if (data_req !== 1'b0 || drain_count !== 4'd1) begin failures++; $display("FAIL single_accept got=%b/%0d exp=0/1", data_req, drain_count); end
        tick();
        checks++; if (data_req !== 1'b1 || data_addr !== 32'h8000_0010) begin failures++; $display("FAIL single_req got=%b/%h exp=1/80000010", data_req, data_addr); end
        checks++; if (data_wdata !== 32'hDEAD_BEEF || data_wstrb !== 4'hf) begin failures++; $display("FAIL single_data got=%h/%h exp=deadbeef/f", data_wdata, data_wstrb); end
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        checks++; if (data_req !== 1'b0 || drain_empty !== 1'b0) begin failures++; $display("FAIL single_wait got=%b/%b exp=0/0", data_req, drain_empty); end
        tick();
        data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;
        checks++; if (drain_empty !== 1'b1 || drain_count !== 4'd0) begin failures++; $display("FAIL single_retire got=%b/%0d exp=1/0", drain_empty, drain_count); end
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < 8; i++) push(32'h1000 + 32'(4*i), 4'hf, 32'hA0 + 32'(i));
        checks++; if (drain_count !== 4'd8 || push_ready !== 1'b0) begin failures++; $display("FAIL fill_full got=%0d/%b exp=8/0", drain_count, push_ready); end
        for (int i = 0; i < 8; i++) begin
            wait_req();
            checks++;
            if (data_req !== 1'b1 || data_addr !== 32'h1000 + 32'(4*i) || data_wdata !== 32'hA0 + 32'(i)) begin
                failures++; $display("FAIL fill_order%0d got=%b/%h/%h exp=1/%h/%h", i, data_req, data_addr, data_wdata, 32'h1000 + 32'(4*i), 32'hA0 + 32'(i));
            end
            retire_one();
        end
        checks++; if (drain_empty !== 1'b1) begin failures++; $display("FAIL fill_drained got=%b exp=1", drain_empty); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) push(32'h2000 + 32'(4*i), 4'hf, 32'hB0 + 32'(i));
        wait_req();
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (data_req !== 1'b1 || data_addr !== 32'h2000 + 32'(4*i)) begin failures++; $display("FAIL b2b_addr%0d got=%b/%h exp=1/%h", i, data_req, data_addr, 32'h2000 + 32'(4*i)); end
            tick();
            checks++; if (drain_count !== 4'(2 - i)) begin failures++; $display("FAIL b2b_count%0d got=%0d exp=%0d", i, drain_count, 2 - i); end
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        checks++; if (data_req !== 1'b0 || drain_empty !== 1'b1) begin failures++; $display("FAIL b2b_end got=%b/%b exp=0/1", data_req, drain_empty); end
    endtask

    task automatic test_push_retire;
        for (int i = 0; i < 3; i++) push(32'h3000 + 32'(4*i), 4'hf, 32'hC0 + 32'(i));
        wait_req();
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; push(32'h300C, 4'hf, 32'hC3); data_data_ok = 1'b0;
        checks++; if (drain_count !== 4'd3) begin failures++; $display("FAIL pr_count got=%0d exp=3", drain_count); end
        checks++; if (data_req !== 1'b1 || data_addr !== 32'h3004) begin failures++; $display("FAIL pr_head got=%b/%h exp=1/3004", data_req, data_addr); end
        retire_one();
        checks++; if (data_addr !== 32'h3008) begin failures++; $display("FAIL pr_next got=%h exp=3008", data_addr); end
        retire_one();
        checks++; if (data_addr !== 32'h300C || data_wdata !== 32'hC3) begin failures++; $display("FAIL pr_tail got=%h/%h exp=300c/c3", data_addr, data_wdata); end
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; push(32'h3010, 4'h3, 32'hC4); data_data_ok = 1'b0;
        checks++; if (drain_count !== 4'd1 || data_req !== 1'b1 || data_addr !== 32'h3010 || data_wstrb !== 4'h3) begin
            failures++; $display("FAIL pr_bypass got=%0d/%b/%h/%h exp=1/1/3010/3", drain_count, data_req, data_addr, data_wstrb);
        end
        retire_one();
        checks++; if (drain_empty !== 1'b1) begin failures++; $display("FAIL pr_end got=%b exp=1", drain_empty); end
    endtask

    task automatic test_conflict;
        push_valid = 1'b1; push_addr = 32'h100; push_wstrb = 4'h1; push_wdata = 32'hAA; ld_addr = 32'h100;
        #1;
        checks++; if (ld_conflict !== 1'b0) begin failures++; $display("FAIL ld_same_cycle got=%b exp=0", ld_conflict); end
        tick(); push_valid = 1'b0;
        ld_addr = 32'h103; #1;
        checks++; if (ld_conflict !== 1'b1) begin failures++; $display("FAIL ld_hit got=%b exp=1", ld_conflict); end
        ld_addr = 32'h104; #1;
        checks++; if (ld_conflict !== 1'b0) begin failures++; $display("FAIL ld_miss got=%b exp=0", ld_conflict); end
        ld_addr = 32'h103;
        wait_req();
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        checks++; if (ld_conflict !== 1'b1) begin failures++; $display("FAIL ld_inflight got=%b exp=1", ld_conflict); end
        data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;
        checks++; if (ld_conflict !== 1'b0) begin failures++; $display("FAIL ld_retired got=%b exp=0", ld_conflict); end
        ld_addr = 32'h0;
    endtask

    task automatic test_merge;
        logic [3:0]  exp_cnt, exp_strb;
        logic [15:0] exp_lo;
`ifdef STORE_MERGE_EN
        exp_cnt = 4'd2; exp_strb = 4'h3; exp_lo = 16'h2211;
`else
        exp_cnt = 4'd3; exp_strb = 4'h1; exp_lo = 16'h0011;
`endif
        push(32'h500, 4'hf, 32'h55);
        push(32'h200, 4'h1, 32'h11);
        push(32'h200, 4'h2, 32'h2200);
        checks++; if (drain_count !== exp_cnt) begin failures++; $display("FAIL merge_count got=%0d exp=%0d", drain_count, exp_cnt); end
        wait_req();
        checks++; if (data_addr !== 32'h500) begin failures++; $display("FAIL merge_head got=%h exp=500", data_addr); end
        retire_one();
        checks++; if (data_addr !== 32'h200 || data_wstrb !== exp_strb || data_wdata[15:0] !== exp_lo) begin
            failures++; $display("FAIL merge_entry got=%h/%h/%h exp=200/%h/%h", data_addr, data_wstrb, data_wdata[15:0], exp_strb, exp_lo);
        end
        for (int k = 0; k < 10 && drain_count != 4'd0; k++) begin
            wait_req();
            retire_one();
        end
        checks++; if (drain_empty !== 1'b1) begin failures++; $display("FAIL merge_end got=%b exp=1", drain_empty); end
    endtask

    task automatic test_reset_wait;
        push(32'h600, 4'hf, 32'h66);
        wait_req();
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        ld_addr = 32'h600; #1;
        checks++; if (ld_conflict !== 1'b1 || data_addr !== 32'h600) begin failures++; $display("FAIL rw_pre got=%b/%h exp=1/600", ld_conflict, data_addr); end
        #2; reset = 1'b0; #1;
        checks++; if (drain_count !== 4'd0 || drain_empty !== 1'b1 || push_ready !== 1'b1) begin
            failures++; $display("FAIL rw_state got=%0d/%b/%b exp=0/1/1", drain_count, drain_empty, push_ready);
        end
        checks++; if (data_req !== 1'b0 || data_addr !== 32'h0 || data_wdata !== 32'h0 || data_wstrb !== 4'h0 || ld_conflict !== 1'b0) begin
            failures++; $display("FAIL rw_outputs got=%b/%h/%h/%h/%b exp=0/0/0/0/0", data_req, data_addr, data_wdata, data_wstrb, ld_conflict);
        end
        @(negedge clk_g); reset = 1'b1;
        tick(); tick();
        checks++; if (data_req !== 1'b0 || drain_empty !== 1'b1) begin failures++; $display("FAIL rw_after got=%b/%b exp=0/1", data_req, drain_empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_push_retire();
        test_conflict();
        test_merge();
        test_reset_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_drain_queue.md
Name: store_drain_queue

Overview:
- Sits directly downstream of the speculative store buffer. Receives stores as they commit.
- Holds them in an in-order FIFO and drains them one at a time to the data-cache SRAM-like port using the req / addr_ok / data_ok handshake.
- Gives the load path a same-word conflict check so loads can stall behind pending committed stores.
- Committed state: pipeline flush never discards entries.

Parameters:
- DATA_WIDTH, 32, width of address and data.
- DEPTH, 8, FIFO entries; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk_g  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- push_valid  in  1  committed store presented this cycle.
- push_addr  in  DATA_WIDTH  byte address.
- push_wstrb  in  4  byte enables; 0 is illegal.
- push_wdata  in  DATA_WIDTH  write data, already byte-lane aligned.
- push_ready  out  1  FIFO can accept this cycle.
- data_req  out  1  cache request.
- data_wr  out  1  constant 1.
- data_wstrb  out  4  byte enables of the head entry.
- data_addr  out  DATA_WIDTH  head address, word-aligned (bits [1:0] = 0).
- data_wdata  out  DATA_WIDTH  head data.
- data_addr_ok  in  1  cache accepted the request.
- data_data_ok  in  1  write completed.
- ld_addr  in  DATA_WIDTH  load address to check.
- ld_conflict  out  1  some valid entry (including the in-flight one) matches ld_addr[31:2].
- drain_empty  out  1  no entries and FSM idle.
- drain_count  out  PTR_W+1  occupied entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - head, tail and count cleared.
  - FSM returns to IDLE.
  - All valid bits cleared.
  - Outputs: data_req=0, push_ready=1, ld_conflict=0, drain_empty=1, drain_count=0.
  - data_addr, data_wdata and data_wstrb are 0.
- Push:
  - Accepted when push_valid && push_ready.
  - Entry is written at tail; tail increments modulo DEPTH.
  - push_ready = (count != DEPTH).
  - Pushing while full is a protocol error; the entry is dropped and the assertion fires.
- FSM has three states.
  - IDLE: if count != 0, go to REQ. data_req is registered, so it asserts the cycle after the first push (minimum latency push to data_req = 1 cycle).
  - REQ:
    - data_req=1 while showing the head entry.
    - Outputs are held stable until data_addr_ok.
    - On addr_ok go to WAIT.
    - If data_addr_ok and data_data_ok arrive in the same cycle, the entry retires and the FSM goes to IDLE or REQ per the remaining count.
  - WAIT:
    - data_req=0.
    - On data_data_ok, retire head: clear its valid bit, head increments modulo DEPTH, count decrements.
    - Then go to REQ if count_after != 0, else IDLE.
- Retirement: only one request is outstanding at a time.
- Push and retire in the same cycle: count unchanged; both pointers advance.
- Full queue: push and retire in the same cycle is legal only if push_ready was 1 at the edge. push_ready does not look ahead to a retire.
- Wrap-around: pointers wrap silently; full and empty are distinguished by count, not by pointer equality.
- ld_conflict is combinational. It compares all valid entries on word address [DATA_WIDTH-1:2], ignoring wstrb.
- A push in the same cycle is not visible to ld_conflict until the next cycle.
- Reset mid-transaction abandons the cache handshake. The cache side is reset together with this block.

Optional Feature:
- Macro: STORE_MERGE_EN.
- When defined:
  - A push whose word address equals the youngest valid entry's word address is merged into that entry.
  - Merge rule: bytes with push_wstrb set overwrite those lanes; wstrb becomes the OR of old and new.
  - count and tail are unchanged.
  - Merging is allowed only if that entry is not the head in REQ/WAIT state.
  - push_ready stays 1 when full if the push would merge.
- When undefined: every push allocates a new entry.

Decomposition:
- Shared cpu package holds:
  - store_entry_t {valid, addr, wstrb, wdata}
  - drain_state_e {DRAIN_IDLE, DRAIN_REQ, DRAIN_WAIT}
- Byte-merge lane logic goes in one natural sub-module, store_byte_merge (old data and strb, new data and strb in; merged data and strb out). It is combinational and reused by the load-forward path.

Test Plan:
- Single push addr=0x8000_0010, wstrb=4'hf, wdata=0xDEADBEEF:
  - data_req rises 1 cycle later with the same values.
  - With addr_ok then data_ok 2 cycles later, drain_empty=1 after retire.
- Fill 8 pushes with the cache stalled (addr_ok=0): push_ready=0 at count=8. Then release; entries drain in push order.
- addr_ok and data_ok in the same cycle on back-to-back entries: one retire per handshake; no duplicate or lost write; count decrements correctly.
- Push while retiring at count=3: count stays 3; tail and head both advance.
- Load conflict check:
  - Pending entry at 0x100 with wstrb=4'h1; ld_addr=0x103 gives ld_conflict=1; ld_addr=0x104 gives 0.
  - After data_ok for that entry, ld_conflict=0.
- STORE_MERGE_EN: push 0x200 wstrb 4'h1 data 0x11, then 0x200 wstrb 4'h2 data 0x2200 while the head is busy elsewhere. Result: count=2, not 3, and the merged entry has wstrb=4'h3, data[15:0]=0x2211. Without the macro, count=3.
- Assert reset low during WAIT: all outputs return to reset values immediately (asynchronously); count=0.
